// File: rtl/aes_key_expander_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_expander_pkg
// Description : Shared widths, FSM encoding, S-box and round-constant helpers
//               for the AES-128 key expander.
// Revision    : 1.0
// ============================================================================
package aes_key_expander_pkg;

    localparam int AES_NR = 10;
    localparam int AES_NK = 4;

    typedef logic [3:0]            u4_t;
    typedef logic [7:0]            u8_t;
    typedef logic [31:0]           u32_t;
    typedef logic [32*AES_NK-1:0]  u128_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    function automatic u8_t rotl8(input u8_t b, input int n);
        return u8_t'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic u8_t gf_mul(input u8_t a, input u8_t b);
        u8_t p;
        u8_t x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8); maps 0 to 0 as AES requires
    function automatic u8_t gf_inv(input u8_t x);
        u8_t sq;
        u8_t r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic u8_t sbox_fwd(input u8_t x);
        u8_t b;
        b = gf_inv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic u8_t sbox_inv(input u8_t x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    function automatic u8_t round_constants(input u4_t r);
        u8_t c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_expander_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_expander_if
// Description : Key-load and round-key read bundle of the AES-128 key expander.
// Revision    : 1.0
// ============================================================================
interface aes_key_expander_if;
    import aes_key_expander_pkg::*;

    u128_t key_in;
    logic  key_start;
    logic  busy;
    logic  done;
    logic  keys_valid;
    u4_t   rk_addr;
    u128_t rk_data;

    modport master (
        output key_in, key_start, rk_addr,
        input  busy, done, keys_valid, rk_data
    );

    modport slave (
        input  key_in, key_start, rk_addr,
        output busy, done, keys_valid, rk_data
    );
endinterface
`default_nettype wire

// File: rtl/aes_key_expander_function_g.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_expander_function_g
// Description : AES g() word transform: RotWord, SubWord, XOR with Rcon.
// Revision    : 1.0
// ============================================================================
module aes_key_expander_function_g
    import aes_key_expander_pkg::*;
(
    input  u32_t i_w,
    input  logic i_encrypt,
    input  u4_t  i_round_no,
    output u32_t o_g
);

    u32_t w_rot;
    u32_t w_sub;

    assign w_rot = {i_w[23:0], i_w[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_byte
        assign w_sub[8*j +: 8] = i_encrypt ? sbox_fwd(w_rot[8*j +: 8])
                                           : sbox_inv(w_rot[8*j +: 8]);
    end

    assign o_g = w_sub ^ {round_constants(i_round_no), 24'h000000};

endmodule
`default_nettype wire

// File: rtl/aes_key_expander.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_expander
// Description : Iterative AES-128 key schedule, one round key per clock, with
//               an 11-entry round-key register file and registered read port.
// Revision    : 1.0
// ============================================================================
module aes_key_expander
    import aes_key_expander_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    aes_key_expander_if.slave kif
);

    localparam int NR = AES_NR;

    state_t r_state_q, w_state_d;
    u4_t    r_round_q, w_round_d;
    logic   r_done_q, w_done_d;
    logic   r_keys_valid_q, w_keys_valid_d;
    u128_t  r_rk_data_q, w_rk_data_d;
    u128_t  r_rk_q [0:NR];

    logic   w_wr_en;
    u4_t    w_wr_idx;
    u128_t  w_wr_data;
    u4_t    w_prev_idx;
    u128_t  w_prev;
    logic   w_round_legal;
    u32_t   w_t, w_n0, w_n1, w_n2, w_n3;

    assign w_prev_idx    = r_round_q - 4'd1;
    assign w_round_legal = (r_round_q != 4'd0) && (r_round_q <= 4'(NR));

    aes_key_expander_function_g u_function_g (
        .i_w        (w_prev[31:0]),
        .i_encrypt  (1'b1),
        .i_round_no (r_round_q),
        .o_g        (w_t)
    );

    assign w_n0 = w_prev[127:96] ^ w_t;
    assign w_n1 = w_prev[95:64]  ^ w_n0;
    assign w_n2 = w_prev[63:32]  ^ w_n1;
    assign w_n3 = w_prev[31:0]   ^ w_n2;

    // Out-of-range indices simply match no entry and read as zero
    always_comb begin
        w_prev      = '0;
        w_rk_data_d = '0;
        for (int i = 0; i <= NR; i++) begin
            if (w_prev_idx == 4'(i))  w_prev      = r_rk_q[i];
            if (kif.rk_addr == 4'(i)) w_rk_data_d = r_rk_q[i];
        end
    end

    always_comb begin
        w_state_d      = r_state_q;
        w_round_d      = r_round_q;
        w_done_d       = 1'b0;
        w_keys_valid_d = r_keys_valid_q;
        w_wr_en        = 1'b0;
        w_wr_idx       = '0;
        w_wr_data      = '0;
        case (r_state_q)
            ST_IDLE: begin
                if (kif.key_start) begin
                    w_state_d      = ST_EXPAND;
                    w_round_d      = 4'd1;
                    w_keys_valid_d = 1'b0;
                    w_wr_en        = 1'b1;
                    w_wr_idx       = 4'd0;
                    w_wr_data      = kif.key_in;
                end
            end
            ST_EXPAND: begin
                if (w_round_legal) begin
                    w_wr_en   = 1'b1;
                    w_wr_idx  = r_round_q;
                    w_wr_data = {w_n0, w_n1, w_n2, w_n3};
                    w_round_d = r_round_q + 4'd1;
                    if (r_round_q == 4'(NR)) begin
                        w_state_d      = ST_IDLE;
                        w_done_d       = 1'b1;
                        w_keys_valid_d = 1'b1;
                    end
                end else begin
                    w_state_d      = ST_IDLE;
                    w_keys_valid_d = 1'b0;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_round_q      <= '0;
            r_done_q       <= 1'b0;
            r_keys_valid_q <= 1'b0;
            r_rk_data_q    <= '0;
            for (int i = 0; i <= NR; i++) r_rk_q[i] <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_round_q      <= w_round_d;
            r_done_q       <= w_done_d;
            r_keys_valid_q <= w_keys_valid_d;
            r_rk_data_q    <= w_rk_data_d;
            for (int i = 0; i <= NR; i++) begin
                if (w_wr_en && (w_wr_idx == 4'(i))) r_rk_q[i] <= w_wr_data;
            end
        end
    end

    assign kif.busy       = (r_state_q == ST_EXPAND);
    assign kif.done       = r_done_q;
    assign kif.keys_valid = r_keys_valid_q;
    assign kif.rk_data    = r_rk_data_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expander.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_expander
// Description : Directed-vector bench for aes_key_expander (FIPS-197 and
//               all-zero key schedules, restart, reset and read-port cases).
// Revision    : 1.0
// ============================================================================
module tb_aes_key_expander;
    import aes_key_expander_pkg::*;

    logic clk = 1'b0;
    logic rst;

    aes_key_expander_if kif ();

    aes_key_expander u_dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] fips_key;
    logic [127:0] exp_fips [0:15];
    logic [127:0] zero_rk1;
    logic [127:0] zero_rk10;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic start_key(input logic [127:0] k);
        kif.key_in    = k;
        kif.key_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kif.key_start = 1'b0;
    endtask

    task automatic read_rk(input int idx, output logic [127:0] d);
        kif.rk_addr = 4'(idx);
        @(posedge clk);
        @(negedge clk);
        d = kif.rk_data;
    endtask

    // Edges after the accepting edge until done is seen; 99 if it never comes
    task automatic wait_done(output int n);
        n = 99;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (kif.done) begin
                n = c;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] d;
        int           n;
        int           pulses;

        fips_key     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp_fips[0]  = fips_key;
        exp_fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 11; i < 16; i++) exp_fips[i] = '0;
        zero_rk1  = 128'h62636363626363636263636362636363;
        zero_rk10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        kif.key_in    = '0;
        kif.key_start = 1'b0;
        kif.rk_addr   = '0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy",       128'(kif.busy),       128'd0);
        check("rst_done",       128'(kif.done),       128'd0);
        check("rst_keys_valid", 128'(kif.keys_valid), 128'd0);
        check("rst_rk_data",    kif.rk_data,          128'd0);
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 key: latency, flags, full read sweep
        start_key(fips_key);
        check("fips_busy_hi",  128'(kif.busy),       128'd1);
        check("fips_kv_lo",    128'(kif.keys_valid), 128'd0);
        wait_done(n);
        check("fips_latency",  128'(n),              128'd10);
        check("fips_kv_hi",    128'(kif.keys_valid), 128'd1);
        check("fips_busy_lo",  128'(kif.busy),       128'd0);
        @(posedge clk);
        @(negedge clk);
        check("fips_done_pulse", 128'(kif.done), 128'd0);
        for (int i = 0; i < 16; i++) begin
            read_rk(i, d);
            check($sformatf("fips_rk%0d", i), d, exp_fips[i]);
        end
        kif.rk_addr = 4'd1;
        #1;
        check("rd_latency_hold", kif.rk_data, 128'd0);
        @(posedge clk);
        #1;
        check("rd_latency_next", kif.rk_data, exp_fips[1]);
        @(negedge clk);

        // All-zero key
        start_key(128'd0);
        wait_done(n);
        check("zero_latency", 128'(n), 128'd10);
        read_rk(0, d);
        check("zero_rk0", d, 128'd0);
        read_rk(1, d);
        check("zero_rk1", d, zero_rk1);
        read_rk(10, d);
        check("zero_rk10", d, zero_rk10);

        // key_start held through EXPAND with a changing key_in is ignored
        kif.key_in    = fips_key;
        kif.key_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kif.key_in = 128'd0;
        wait_done(n);
        kif.key_start = 1'b0;
        check("hold_latency", 128'(n), 128'd10);
        pulses = 0;
        repeat (14) begin
            @(posedge clk);
            @(negedge clk);
            if (kif.done) pulses++;
        end
        check("hold_extra_done", 128'(pulses),   128'd0);
        check("hold_busy_lo",    128'(kif.busy), 128'd0);
        read_rk(1, d);
        check("hold_rk1", d, exp_fips[1]);
        read_rk(10, d);
        check("hold_rk10", d, exp_fips[10]);

        // Asynchronous reset mid-expansion
        start_key(128'd0);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("mid_busy_hi", 128'(kif.busy), 128'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy",       128'(kif.busy),       128'd0);
        check("mid_rst_keys_valid", 128'(kif.keys_valid), 128'd0);
        check("mid_rst_done",       128'(kif.done),       128'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            read_rk(i, d);
            check($sformatf("mid_rst_rk%0d", i), d, 128'd0);
        end
        start_key(fips_key);
        wait_done(n);
        check("post_rst_latency", 128'(n), 128'd10);
        read_rk(5, d);
        check("post_rst_rk5", d, exp_fips[5]);
        read_rk(10, d);
        check("post_rst_rk10", d, exp_fips[10]);

        // Back-to-back: restart accepted in the done cycle
        start_key(128'd0);
        wait_done(n);
        check("b2b_first_latency", 128'(n), 128'd10);
        kif.key_in    = fips_key;
        kif.key_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kif.key_start = 1'b0;
        check("b2b_kv_drop",  128'(kif.keys_valid), 128'd0);
        check("b2b_busy_hi",  128'(kif.busy),       128'd1);
        check("b2b_done_lo",  128'(kif.done),       128'd0);
        wait_done(n);
        check("b2b_second_latency", 128'(n),              128'd10);
        check("b2b_kv_hi",          128'(kif.keys_valid), 128'd1);
        read_rk(1, d);
        check("b2b_rk1", d, exp_fips[1]);
        read_rk(10, d);
        check("b2b_rk10", d, exp_fips[10]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
